// File: rtl/snn_spike_encoder_if.sv
// Stream bundle for snn_spike_encoder: frame control, intensity input beats and spike-word output.
// The out_step_count signal exists only when SNN_ENC_SPIKE_COUNT_EN is defined.
interface snn_spike_encoder_if #(
    parameter int NUM_FEATURES = 8192,
    parameter int NUM_STEPS    = 10,
    parameter int INT_WIDTH    = 8
);
    localparam int WORDS_PER_STEP = NUM_FEATURES / 32;
    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int WIDX_W = (WORDS_PER_STEP > 1) ? $clog2(WORDS_PER_STEP) : 1;
    localparam int CNT_W  = $clog2(NUM_FEATURES + 1);

    logic                 start;
    logic                 feat_valid;
    logic                 feat_ready;
    logic [INT_WIDTH-1:0] feat_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_data;
    logic [STEP_W-1:0]    out_step;
    logic [WIDX_W-1:0]    out_word_idx;
    logic                 out_last;
    logic                 done;
`ifdef SNN_ENC_SPIKE_COUNT_EN
    logic [CNT_W-1:0]     out_step_count;

    modport master (
        output start, feat_valid, feat_data, out_ready,
        input  feat_ready, out_valid, out_data, out_step, out_word_idx, out_last, done,
               out_step_count
    );
    modport slave (
        input  start, feat_valid, feat_data, out_ready,
        output feat_ready, out_valid, out_data, out_step, out_word_idx, out_last, done,
               out_step_count
    );
`else
    modport master (
        output start, feat_valid, feat_data, out_ready,
        input  feat_ready, out_valid, out_data, out_step, out_word_idx, out_last, done
    );
    modport slave (
        input  start, feat_valid, feat_data, out_ready,
        output feat_ready, out_valid, out_data, out_step, out_word_idx, out_last, done
    );
`endif
endinterface

// File: rtl/snn_spike_encoder.sv
// Sigma-delta rate encoder: one frame of intensities becomes NUM_STEPS x WORDS_PER_STEP packed spike words.
// Optional per-step spike count output is enabled by defining SNN_ENC_SPIKE_COUNT_EN.
module snn_spike_encoder #(
    parameter int NUM_FEATURES   = 8192,
    parameter int NUM_STEPS      = 10,
    parameter int WORDS_PER_STEP = NUM_FEATURES / 32,
    parameter int INT_WIDTH      = 8,
    parameter int PHASE_INIT     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    snn_spike_encoder_if.slave   bus
);
    localparam int IDX_W  = $clog2(NUM_FEATURES);
    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int WIDX_W = (WORDS_PER_STEP > 1) ? $clog2(WORDS_PER_STEP) : 1;
`ifdef SNN_ENC_SPIKE_COUNT_EN
    localparam int CNT_W  = $clog2(NUM_FEATURES + 1);
`endif
    localparam logic [IDX_W-1:0]  LAST_F    = IDX_W'(NUM_FEATURES - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ENCODE, S_FLUSH, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [31:0]          shift_q, shift_d;
    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_data_q, out_data_d;
    logic [STEP_W-1:0]    out_step_q, out_step_d;
    logic [WIDX_W-1:0]    out_widx_q, out_widx_d;
    logic                 out_last_q, out_last_d;
`ifdef SNN_ENC_SPIKE_COUNT_EN
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_sum;
    logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
`endif

    logic [INT_WIDTH-1:0] intensity_mem [NUM_FEATURES];
    logic [INT_WIDTH-1:0] phase_mem     [NUM_FEATURES];
    logic [INT_WIDTH-1:0] int_rd_q, ph_rd_q;
    logic [IDX_W-1:0]     rd_addr;
    logic                 int_we, ph_we;
    logic [INT_WIDTH-1:0] ph_wdata;
    logic [INT_WIDTH:0]   sum;
    logic                 spike, advance, drain;

    // Both memories are written at idx_q; the read side prefetches the feature processed next cycle.
    always_ff @(posedge clk) begin
        if (int_we) intensity_mem[idx_q] <= bus.feat_data;
        if (ph_we)  phase_mem[idx_q]     <= ph_wdata;
        int_rd_q <= intensity_mem[rd_addr];
        ph_rd_q  <= phase_mem[rd_addr];
    end

    assign sum     = {1'b0, ph_rd_q} + {1'b0, int_rd_q};
    assign spike   = sum[INT_WIDTH];
    assign drain   = out_valid_q && bus.out_ready;
    assign advance = !out_valid_q || bus.out_ready;
`ifdef SNN_ENC_SPIKE_COUNT_EN
    assign cnt_sum = cnt_q + CNT_W'(spike);
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        step_d      = step_q;
        shift_d     = shift_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_step_d  = out_step_q;
        out_widx_d  = out_widx_q;
        out_last_d  = out_last_q;
`ifdef SNN_ENC_SPIKE_COUNT_EN
        cnt_d       = cnt_q;
        out_cnt_d   = out_cnt_q;
`endif
        int_we      = 1'b0;
        ph_we       = 1'b0;
        ph_wdata    = sum[INT_WIDTH-1:0];
        rd_addr     = '0;

        if (drain) out_valid_d = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    step_d  = '0;
`ifdef SNN_ENC_SPIKE_COUNT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_LOAD: begin
                if (bus.feat_valid) begin
                    int_we   = 1'b1;
                    ph_we    = 1'b1;
                    ph_wdata = INT_WIDTH'(PHASE_INIT);
                    if (idx_q == LAST_F) begin
                        idx_d   = '0;
                        state_d = S_ENCODE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_ENCODE: begin
                rd_addr = idx_q;
                if (advance) begin
                    ph_we   = 1'b1;
                    shift_d = {spike, shift_q[31:1]};
                    rd_addr = (idx_q == LAST_F) ? '0 : idx_q + IDX_W'(1);
                    // Bit 31 completes a word: it lands in the output register this cycle.
                    if (idx_q[4:0] == 5'd31) begin
                        out_valid_d = 1'b1;
                        out_data_d  = shift_d;
                        out_step_d  = step_q;
                        out_widx_d  = WIDX_W'(idx_q >> 5);
                        out_last_d  = (step_q == LAST_STEP) && (idx_q == LAST_F);
`ifdef SNN_ENC_SPIKE_COUNT_EN
                        out_cnt_d   = (idx_q == LAST_F) ? cnt_sum : '0;
`endif
                    end
`ifdef SNN_ENC_SPIKE_COUNT_EN
                    cnt_d = (idx_q == LAST_F) ? '0 : cnt_sum;
`endif
                    if (idx_q == LAST_F) begin
                        idx_d = '0;
                        if (step_q == LAST_STEP) state_d = S_FLUSH;
                        else                     step_d  = step_q + STEP_W'(1);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (drain) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            step_q      <= '0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_step_q  <= '0;
            out_widx_q  <= '0;
            out_last_q  <= 1'b0;
`ifdef SNN_ENC_SPIKE_COUNT_EN
            cnt_q       <= '0;
            out_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            step_q      <= step_d;
            shift_q     <= shift_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_step_q  <= out_step_d;
            out_widx_q  <= out_widx_d;
            out_last_q  <= out_last_d;
`ifdef SNN_ENC_SPIKE_COUNT_EN
            cnt_q       <= cnt_d;
            out_cnt_q   <= out_cnt_d;
`endif
        end
    end

    assign bus.feat_ready   = (state_q == S_LOAD);
    assign bus.done         = (state_q == S_DONE);
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_step     = out_step_q;
    assign bus.out_word_idx = out_widx_q;
    assign bus.out_last     = out_last_q;
`ifdef SNN_ENC_SPIKE_COUNT_EN
    assign bus.out_step_count = out_cnt_q;
`endif
endmodule

// File: tb/tb_snn_spike_encoder.sv
// Scoreboard bench for snn_spike_encoder on a reduced 256-feature frame (8 words per step, 80 words per frame).
module tb_snn_spike_encoder;
    localparam int NF = 256;
    localparam int NS = 10;
    localparam int IW = 8;
    localparam int WPS = NF / 32;
    localparam int TOTAL = NS * WPS;
    localparam int STEP_W = $clog2(NS);
    localparam int WIDX_W = $clog2(WPS);
    localparam int STALL_LEN = 100;
`ifdef SNN_ENC_SPIKE_COUNT_EN
    localparam int CNT_W = $clog2(NF + 1);
`endif

    typedef struct packed {
        logic [31:0]       data;
        logic [STEP_W-1:0] step;
        logic [WIDX_W-1:0] idx;
        logic              last;
`ifdef SNN_ENC_SPIKE_COUNT_EN
        logic [CNT_W-1:0]  cnt;
`endif
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snn_spike_encoder_if #(.NUM_FEATURES(NF), .NUM_STEPS(NS), .INT_WIDTH(IW)) bus ();

    snn_spike_encoder #(
        .NUM_FEATURES(NF), .NUM_STEPS(NS), .WORDS_PER_STEP(WPS), .INT_WIDTH(IW), .PHASE_INIT(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    word_t exp_q[$];
    word_t obs_q[$];
    int    intens[NF];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    hold_bad;
    int    stall_seen;

    function automatic logic [31:0] rule_word(input int mode, input int s, input int w);
        case (mode)
            1:       return (s == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF;
            2:       return (w == 0 && (s % 2) == 1) ? 32'h0000_0001 : 32'h0000_0000;
            3:       return (w == 1 && (s == 3 || s == 7)) ? 32'h0000_0002 : 32'h0000_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic word_t cur_word();
        word_t c;
        c.data = bus.out_data;
        c.step = bus.out_step;
        c.idx  = bus.out_word_idx;
        c.last = bus.out_last;
`ifdef SNN_ENC_SPIKE_COUNT_EN
        c.cnt  = bus.out_step_count;
`endif
        return c;
    endfunction

    task automatic set_intens(input int mode);
        for (int f = 0; f < NF; f++) begin
            case (mode)
                1:       intens[f] = 255;
                2:       intens[f] = (f == 0) ? 128 : 0;
                3:       intens[f] = (f == 33) ? 64 : 0;
                4:       intens[f] = $urandom_range(0, 255);
                default: intens[f] = 0;
            endcase
        end
    endtask

    // Modes 0-3 use hand-derived patterns; mode 4 (random) uses a sigma-delta reference.
    task automatic push_expected(input int mode);
        int ph[NF];
        logic [31:0] w[WPS];
        int cnt, sum;
        word_t e;
        for (int f = 0; f < NF; f++) ph[f] = 0;
        for (int s = 0; s < NS; s++) begin
            cnt = 0;
            for (int wi = 0; wi < WPS; wi++) w[wi] = (mode == 4) ? 32'h0 : rule_word(mode, s, wi);
            if (mode == 4) begin
                for (int f = 0; f < NF; f++) begin
                    sum = ph[f] + intens[f];
                    if (sum >= 256) w[f / 32][f % 32] = 1'b1;
                    ph[f] = sum % 256;
                end
            end
            for (int wi = 0; wi < WPS; wi++) cnt += $countones(w[wi]);
            for (int wi = 0; wi < WPS; wi++) begin
                e = '0;
                e.data = w[wi];
                e.step = STEP_W'(s);
                e.idx  = WIDX_W'(wi);
                e.last = (s == NS - 1) && (wi == WPS - 1);
`ifdef SNN_ENC_SPIKE_COUNT_EN
                e.cnt  = (wi == WPS - 1) ? CNT_W'(cnt) : '0;
`endif
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic load_frame();
        int i = 0;
        int guard = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.feat_valid = 1'b1;
        while (i < NF && guard < 4 * NF) begin
            bus.feat_data = 8'(intens[i]);
            if (bus.feat_ready) i++;
            @(negedge clk);
            guard++;
        end
        bus.feat_valid = 1'b0;
    endtask

    task automatic collect(input int n_words, input int stall_word);
        int got = 0;
        int cyc = 0;
        int stall_cnt = 0;
        word_t ref_w, cur;
        ref_w = '0;
        while (got < n_words && cyc < n_words * 40 + 400) begin
            @(negedge clk);
            cyc++;
            cur = cur_word();
            if (got == stall_word && bus.out_valid && stall_cnt < STALL_LEN) begin
                if (stall_cnt == 0) ref_w = cur;
                else if (cur !== ref_w) hold_bad++;
                stall_cnt++;
                bus.out_ready = 1'b0;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                obs_q.push_back(cur);
                $display("[TB] word %0d data=%h step=%0d idx=%0d last=%0d", got, cur.data, cur.step, cur.idx, cur.last);
                got++;
            end
        end
        stall_seen = stall_cnt;
        bus.out_ready = 1'b1;
    endtask

    task automatic run_frame(input int mode, input int n_words, input int stall_word);
        exp_q.delete();
        obs_q.delete();
        hold_bad = 0;
        set_intens(mode);
        push_expected(mode);
        load_frame();
        collect(n_words, stall_word);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (bus.feat_ready !== 1'b0) begin n_fail++; $display("FAIL reset feat_ready: got %b want 0", bus.feat_ready); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset out_data: got %h want 0", bus.out_data); end
        n_tests++; if ({bus.out_step, bus.out_word_idx, bus.out_last} !== '0) begin
            n_fail++; $display("FAIL reset out_step/idx/last: got %0d/%0d/%b want 0/0/0", bus.out_step, bus.out_word_idx, bus.out_last);
        end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", bus.done); end
        rst = 1'b0;
    endtask

    task automatic test_all_zero();
        word_t e, o;
        run_frame(0, TOTAL, -1);
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero done_early: got %b want 0", bus.done); end
        @(negedge clk);
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero done_after_last: got %b want 1", bus.done); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL zero word %0d: got none want %h", k, e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL zero word %0d: got %h want %h", k, o, e); end end
        end
    endtask

    task automatic test_all_max();
        word_t e, o;
        run_frame(1, TOTAL, -1);
        @(negedge clk);
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL max done: got %b want 1", bus.done); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL max word %0d: got none want %h", k, e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL max word %0d: got %h want %h", k, o, e); end end
        end
    endtask

    task automatic test_feat0_half();
        word_t e, o;
        run_frame(2, TOTAL, -1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL feat0 word %0d: got none want %h", k, e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL feat0 word %0d: got %h want %h", k, o, e); end end
        end
    endtask

    task automatic test_feat33_quarter();
        word_t e, o;
        run_frame(3, TOTAL, -1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL feat33 word %0d: got none want %h", k, e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL feat33 word %0d: got %h want %h", k, o, e); end end
        end
    endtask

    task automatic test_stall();
        word_t e, o;
        run_frame(4, TOTAL, 5);
        n_tests++; if (stall_seen !== STALL_LEN) begin n_fail++; $display("FAIL stall cycles: got %0d want %0d", stall_seen, STALL_LEN); end
        n_tests++; if (hold_bad !== 0) begin n_fail++; $display("FAIL stall hold: got %0d changes want 0", hold_bad); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL stall word %0d: got none want %h", k, e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL stall word %0d: got %h want %h", k, o, e); end end
        end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(1, 50, -1);
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst done: got %b want 0", bus.done); end
        n_tests++; if (bus.feat_ready !== 1'b0) begin n_fail++; $display("FAIL midrst feat_ready: got %b want 0", bus.feat_ready); end
        rst = 1'b0;
        test_all_max();
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.feat_valid = 1'b0;
        bus.feat_data  = '0;
        bus.out_ready  = 1'b1;
        test_reset();
        test_all_zero();
        test_all_max();
        test_feat0_half();
        test_feat33_quarter();
        test_stall();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
